// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the windowed multi-channel debouncer.
// Defaults describe a 500-sample window with 3/4 and 1/4 hysteresis thresholds.
package debounce_pkg;

  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_CYCLES      = 500;
  localparam int DEF_SYNC_STAGES = 2;

  // Counters must hold CYCLES itself: a full window of ones plus the closing sample.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  function automatic int thresh_hi_default(input int cycles);
    return cycles * 3 / 4;
  endfunction

  function automatic int thresh_lo_default(input int cycles);
    return cycles / 4;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, ones accumulator and hysteresis decision.
// Decision registers update only on the shared win_end; clear discards the partial window.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CYCLES      = DEF_CYCLES,
  parameter int THRESH_HI   = thresh_hi_default(CYCLES),
  parameter int THRESH_LO   = thresh_lo_default(CYCLES),
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = cnt_width(CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  input  logic win_end,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] HI = CNT_W'(THRESH_HI);
  localparam logic [CNT_W-1:0] LO = CNT_W'(THRESH_LO);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       acc;
  logic [CNT_W-1:0]       total;

  assign s     = sync[SYNC_STAGES-1];
  assign total = acc + {{(CNT_W-1){1'b0}}, s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= win_end ? '0 : total;
    end
  end

  // win_end already excludes clear cycles, so strobes here need no clear term.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (win_end) begin
        if (total >= HI && !out) begin
          out  <= 1'b1;
          rise <= 1'b1;
        end else if (total <= LO && out) begin
          out  <= 1'b0;
          fall <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel windowed majority debouncer; all channels share one window counter.
// window_done pulses one cycle with the decision update; en freezes, clear restarts the window.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int CYCLES      = DEF_CYCLES,
  parameter int THRESH_HI   = thresh_hi_default(CYCLES),
  parameter int THRESH_LO   = thresh_lo_default(CYCLES),
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clear,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                window_done
);

  localparam int               CNT_W = cnt_width(CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] wcnt;
  logic             win_end;

  // clear wins over a coincident window end: no decision that cycle.
  assign win_end = en && !clear && (wcnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt        <= '0;
      window_done <= 1'b0;
    end else begin
      window_done <= win_end;
      if (clear) begin
        wcnt <= '0;
      end else if (en) begin
        wcnt <= win_end ? '0 : wcnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .CYCLES      (CYCLES),
      .THRESH_HI   (THRESH_HI),
      .THRESH_LO   (THRESH_LO),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clear   (clear),
      .win_end (win_end),
      .in      (in[i]),
      .out     (out[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

endmodule
